// File: rtl/ls138_scan.sv
// Registered WIDTH-to-2**WIDTH active-low decoder with TTL-style three-input
// enable and a prescaled auto-scan index counter for display/keypad strobing.

module ls138_scan_lane #(
   parameter int WIDTH = 3,
   parameter int LANE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] idx_d,
   output logic             y
);
   localparam logic [WIDTH-1:0] MY_IDX = WIDTH'(LANE);

   // Decoding idx_d (not the registered index) keeps _Y aligned with _IDX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) y <= 1'b1;
      else     y <= ~(en && (idx_d == MY_IDX));
   end
endmodule

module ls138_scan #(
   parameter int WIDTH  = 3,
   parameter int DIVIDE = 4,
   parameter int LAST   = 2**WIDTH - 1
) (
   input  logic                  _CLK,
   input  logic                  _RST,
   input  logic [WIDTH-1:0]      _SEL,
   input  logic                  _G1,
   input  logic                  _G2A,
   input  logic                  _G2B,
   input  logic                  _MODE,
   input  logic                  _LOAD,
   output logic [2**WIDTH-1:0]   _Y,
   output logic [WIDTH-1:0]      _IDX,
   output logic                  _TC
);
   localparam int NUM_LANES = 2**WIDTH;
   localparam int PW        = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
   localparam logic [PW-1:0]    PRE_MAX = PW'(DIVIDE - 1);
   localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(LAST);

   logic             en;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] idx_d;
   logic             tc_d;

   assign en = _G1 & ~_G2A & ~_G2B;

   // Load beats enable; an index parked above LAST wraps on its next step.
   always_comb begin
      idx_d = _IDX;
      pre_d = pre_q;
      tc_d  = 1'b0;
      if (!_MODE) begin
         idx_d = _SEL;
         pre_d = '0;
      end else if (_LOAD) begin
         idx_d = _SEL;
         pre_d = '0;
      end else if (en) begin
         if (pre_q != PRE_MAX) begin
            pre_d = pre_q + 1'b1;
         end else begin
            pre_d = '0;
            if (_IDX >= LAST_W) begin
               idx_d = '0;
               tc_d  = 1'b1;
            end else begin
               idx_d = _IDX + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge _CLK or posedge _RST) begin
      if (_RST) begin
         pre_q <= '0;
         _IDX  <= '0;
         _TC   <= 1'b0;
      end else begin
         pre_q <= pre_d;
         _IDX  <= idx_d;
         _TC   <= tc_d;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
      ls138_scan_lane #(.WIDTH(WIDTH), .LANE(i)) u_lane (
         .clk   (_CLK),
         .rst   (_RST),
         .en    (en),
         .idx_d (idx_d),
         .y     (_Y[i])
      );
   end
endmodule
